// File: rtl/jam_cost_table.sv
// Cost matrix store for the job-assignment search engine: loads an 8x8 matrix over a
// valid/ready stream, serves combinational reads and accumulates the row-minimum lower bound.
module jam_cost_table #(
    parameter int N_WORKER = 8,
    parameter int COST_W   = 7,
    parameter int SUM_W    = 10
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [COST_W-1:0] in_data,
    input  logic              in_last,
    input  logic              reload,
    input  logic [2:0]        W,
    input  logic [2:0]        J,
    output logic [COST_W-1:0] Cost,
    output logic              table_ready,
    output logic              load_err,
    output logic [SUM_W-1:0]  LowerBound
);

    localparam int N_ENTRY = N_WORKER * N_WORKER;
    localparam logic [COST_W-1:0] COST_MAX = '1;

    typedef enum logic [1:0] {IDLE, LOAD, READY, ERR} state_t;

    state_t             state_reg, state_next;
    logic [5:0]         cnt_reg;
    logic [COST_W-1:0]  row_min_reg;
    logic [SUM_W-1:0]   lower_bound_reg;
    logic [COST_W-1:0]  mem_reg [N_ENTRY];
    logic [N_ENTRY-1:0] wr_en;
    logic               accept;
    logic               restart;
    logic [COST_W-1:0]  cand_min;

    assign accept   = in_valid && (state_reg == LOAD);
    assign restart  = reload && ((state_reg == READY) || (state_reg == ERR));
    assign cand_min = (in_data < row_min_reg) ? in_data : row_min_reg;

    // One-hot write decode from the entry counter
    generate
        for (genvar gi = 0; gi < N_ENTRY; gi++) begin : g_wr_en
            assign wr_en[gi] = accept && (cnt_reg == 6'(gi));
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  state_next = LOAD;
            LOAD: begin
                if (accept) begin
                    if (cnt_reg == 6'd63) begin
                        state_next = in_last ? READY : ERR;
                    end else if (in_last) begin
                        state_next = ERR;
                    end
                end
            end
            READY: if (reload) state_next = LOAD;
            ERR:   if (reload) state_next = LOAD;
            default: state_next = IDLE;
        endcase
    end

    // Counter and running lower bound; a row closes on its eighth entry
    always_ff @(posedge CLK) begin
        if (RST || restart) begin
            cnt_reg         <= '0;
            row_min_reg     <= COST_MAX;
            lower_bound_reg <= '0;
        end else if (accept) begin
            cnt_reg <= cnt_reg + 6'd1;
            if (cnt_reg[2:0] == 3'd7) begin
                lower_bound_reg <= lower_bound_reg + SUM_W'(cand_min);
                row_min_reg     <= COST_MAX;
            end else begin
                row_min_reg <= cand_min;
            end
        end
    end

    // Array survives reload; only reset clears it
    always_ff @(posedge CLK) begin
        for (int i = 0; i < N_ENTRY; i++) begin
            if (RST) begin
                mem_reg[i] <= '0;
            end else if (wr_en[i]) begin
                mem_reg[i] <= in_data;
            end
        end
    end

    assign Cost        = mem_reg[{W, J}];
    assign in_ready    = (state_reg == LOAD);
    assign table_ready = (state_reg == READY);
    assign load_err    = (state_reg == ERR);
    assign LowerBound  = lower_bound_reg;

endmodule

// File: doc/jam_cost_table.md
Name: jam_cost_table

Overview:
- Upstream cost store for the job-assignment (JAM) search engine. Accepts an 8x8 worker/job cost matrix over a valid/ready byte stream and holds it in registers.
- Serves combinational Cost reads addressed by the engine's W/J outputs.
- Computes the sum of per-worker row minima (LowerBound) during load, for pruning and sanity checks.
- Asserts table_ready to release the engine once a complete, well-framed matrix is loaded.

Parameters:
- N_WORKER, 8, matrix dimension. Workers and jobs are both 0..7. Fixed: address math assumes 3-bit W/J.
- COST_W, 7, bits per cost entry.
- SUM_W, 10, LowerBound width. Max value is 8*127 = 1016.

Ports:
- CLK, input, 1, clock. All state updates on the rising edge.
- RST, input, 1, reset. Synchronous, active-high.
- in_valid, input, 1, load stream entry valid.
- in_ready, output, 1, block accepts an entry this cycle.
- in_data, input, 7, cost entry. Row-major order: entry k = cost[W=k/8][J=k%8].
- in_last, input, 1, marks the final entry of a matrix. Sampled only on an accepted entry.
- reload, input, 1, one-cycle request to discard the table and start a new load.
- W, input, 3, read worker index.
- J, input, 3, read job index.
- Cost, output, 7, cost[W][J]. Combinational from the registered array.
- table_ready, output, 1, full matrix loaded without framing error.
- load_err, output, 1, sticky framing error.
- LowerBound, output, 10, sum over rows of min(cost[w][*]).

Behaviour:
- Handshake: an entry is accepted on an edge where in_valid & in_ready.
  - cnt (6-bit) advances only on acceptance.
  - in_data/in_last are ignored when not accepted.
  - in_valid may drop at any time; bubbles are legal.
- States: IDLE, LOAD, READY, ERR.
- On RST:
  - state=IDLE; cnt=0; all 64 entries cleared to 0.
  - row_min=127; LowerBound=0; table_ready=0; load_err=0; in_ready=0.
  - Cost therefore reads 0 until loaded. RST mid-load discards everything.
- IDLE: in_ready=0. Moves to LOAD on the next edge unconditionally.
- LOAD: in_ready=1. On each accept:
  - mem[cnt] <= in_data; cnt <= cnt+1.
  - If cnt[2:0]!=7: row_min <= min(row_min, in_data).
  - If cnt[2:0]==7: LowerBound <= LowerBound + min(row_min, in_data); row_min <= 127.
  - Accept with in_last=1 and cnt<63: ERR (early termination). The entry is still written.
  - Accept with cnt==63 and in_last=0: ERR (missing frame end). The entry is written and LowerBound still updates.
  - Accept with cnt==63 and in_last=1: READY.
  - reload is ignored in LOAD.
- READY:
  - table_ready=1, in_ready=0.
  - table_ready rises on the edge that accepts entry 63. It is visible the cycle after the last handshake.
  - LowerBound is final and stable. It shows partial sums during LOAD; it is only meaningful when table_ready=1.
- ERR: load_err=1, in_ready=0, table_ready=0. The array holds whatever was written.
- reload in READY or ERR, on that edge:
  - state=LOAD; cnt=0; LowerBound=0; row_min=127; load_err=0; table_ready=0.
  - Array contents are kept and overwritten entry by entry.
- Read path:
  - Cost = mem[{W,J}], zero-cycle latency and valid in every state.
  - The engine drives registered W/J and sums Cost in the same cycle, so no output register is allowed on Cost.
  - W/J are don't-care to load logic; simultaneous read and write of the same entry returns the old value.
- Arithmetic:
  - Compares are unsigned 7-bit.
  - LowerBound adds are zero-extended to 10 bits. Overflow is impossible.
- Target 120–250 lines of RTL. 64x7 register array with synchronous clear; no RAM macro.

Test Plan:
- Load cost[w][j]=w*8+j with no bubbles, in_last on entry 63 → table_ready=1 exactly one cycle after the 64th handshake; LowerBound=224; W=3,J=5 → Cost=29; W=7,J=7 → Cost=63.
- Same matrix with in_valid toggling every other cycle and random 0–3 cycle gaps → identical cnt progression per handshake, same final values; no entry dropped or duplicated.
- in_last on entry 10 → next cycle load_err=1, in_ready=0, table_ready=0. Pulse reload → load_err=0, in_ready=1, then a full correct load → table_ready=1.
- 64 entries with in_last never set → load_err=1 after entry 63, table_ready stays 0. Reload is ignored while in LOAD.
- All entries 127 → LowerBound=1016. Reload with all entries 0 → LowerBound=0, Cost=0 at every W/J. Rows with the minimum in column 0 or 7 (e.g. row=[5,9,...,9] and [9,...,9,2]) → contribute 5 and 2.
- RST asserted after 30 entries → next cycle in_ready=0, Cost=0 for all W/J. One cycle later in_ready=1 and the next accept writes entry 0.
